// File: rtl/projectile_ctl.sv
// -----------------------------------------------------------------------------
// projectile_ctl
//
// Turn-based throw scheduler and ballistic sequencer for the cat and dog
// projectiles. A throw request from the side whose turn it is gets accepted.
// Launch velocities come from the requester's power. The projectile then
// moves once per video frame under constant gravity until it reaches the
// ground or the far edge of the field. It stays visible for HOLD_FRAMES
// frames and then hands the turn to the other side.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   cat_req     cat throw request, held until cat_grant
//   cat_power   cat launch power, 0..127
//   dog_req     dog throw request, held until dog_grant
//   dog_power   dog launch power, 0..127
//   cat_grant   one-cycle acknowledge of cat_req
//   dog_grant   one-cycle acknowledge of dog_req
//   active      projectile visible
//   x_pos       horizontal offset from the thrower's edge (mirrored by draw)
//   y_pos       height above screen bottom, floored at 0
//   owner       thrower of the current projectile (0 = cat, 1 = dog)
//   turn        side allowed to throw next (0 = cat, 1 = dog)
//   landed      one-cycle pulse when the flight ends
//
// Handshake: a side raises req and holds it. In IDLE, only the req that
// matches turn is sampled. It is acknowledged by a one-cycle grant in the
// cycle after sampling. The requester drops req within one cycle of the
// grant. The other side's req is neither sampled nor acknowledged.
// -----------------------------------------------------------------------------
module projectile_ctl #(
    parameter int START_X     = 40,
    parameter int START_Y     = 100,
    parameter int GROUND_Y    = 15,
    parameter int X_LIMIT     = 785,
    parameter int GRAVITY     = 1,
    parameter int HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        cat_req,
    input  logic [6:0]  cat_power,
    input  logic        dog_req,
    input  logic [6:0]  dog_power,
    output logic        cat_grant,
    output logic        dog_grant,
    output logic        active,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        owner,
    output logic        turn,
    output logic        landed
);

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [11:0]        START_X_V  = 12'(START_X);
    localparam logic [11:0]        X_LIMIT_V  = 12'(X_LIMIT);
    localparam logic signed [12:0] START_Y_S  = 13'(START_Y);
    localparam logic signed [12:0] GROUND_Y_S = 13'(GROUND_Y);
    localparam logic signed [7:0]  GRAVITY_S  = 8'(GRAVITY);
    localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Current state is kept under a stable name so checkers can bind to it.
    state_t state, state_nx;

    logic [11:0]        x, x_nx;
    logic signed [12:0] y, y_nx;
    logic [3:0]         vx, vx_nx;
    logic signed [7:0]  vy, vy_nx;
    logic [HW-1:0]      hold_cnt, hold_cnt_nx;

    logic turn_nx, owner_nx, active_nx;
    logic cat_grant_nx, dog_grant_nx, landed_nx;

    logic               req_sel;
    logic [6:0]         power_sel;
    logic [11:0]        x_sum;
    logic signed [12:0] y_sum;

    // The request and power of the side whose turn it is.
    assign req_sel   = turn ? dog_req : cat_req;
    assign power_sel = turn ? dog_power : cat_power;

    // Next position candidates, computed from the current velocity.
    assign x_sum = x + {8'd0, vx};
    assign y_sum = y + $signed({{5{vy[7]}}, vy});

    always_comb begin
        state_nx     = state;
        x_nx         = x;
        y_nx         = y;
        vx_nx        = vx;
        vy_nx        = vy;
        hold_cnt_nx  = hold_cnt;
        turn_nx      = turn;
        owner_nx     = owner;
        active_nx    = active;
        cat_grant_nx = 1'b0;
        dog_grant_nx = 1'b0;
        landed_nx    = 1'b0;

        case (state)
            IDLE: begin
                // frame_tick is ignored here, so a tick in the launch
                // cycle causes no motion.
                if (req_sel) begin
                    cat_grant_nx = ~turn;
                    dog_grant_nx = turn;
                    vx_nx        = 4'(power_sel >> 4) + 4'd2;
                    vy_nx        = $signed(8'(power_sel >> 2) + 8'd4);
                    x_nx         = START_X_V;
                    y_nx         = START_Y_S;
                    owner_nx     = turn;
                    active_nx    = 1'b1;
                    state_nx     = FLY;
                end
            end

            FLY: begin
                if (frame_tick) begin
                    // The ground check has priority over the far-edge check.
                    if (y_sum < GROUND_Y_S) begin
                        y_nx        = GROUND_Y_S;
                        x_nx        = (x_sum > X_LIMIT_V) ? X_LIMIT_V : x_sum;
                        landed_nx   = 1'b1;
                        hold_cnt_nx = '0;
                        state_nx    = HOLD;
                    end else if (x_sum > X_LIMIT_V) begin
                        x_nx        = X_LIMIT_V;
                        y_nx        = y_sum;
                        landed_nx   = 1'b1;
                        hold_cnt_nx = '0;
                        state_nx    = HOLD;
                    end else begin
                        x_nx  = x_sum;
                        y_nx  = y_sum;
                        vy_nx = vy - GRAVITY_S;
                    end
                end
            end

            HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        active_nx = 1'b0;
                        turn_nx   = ~turn;
                        state_nx  = IDLE;
                    end else begin
                        hold_cnt_nx = hold_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            vx        <= '0;
            vy        <= '0;
            hold_cnt  <= '0;
            turn      <= 1'b0;
            owner     <= 1'b0;
            active    <= 1'b0;
            cat_grant <= 1'b0;
            dog_grant <= 1'b0;
            landed    <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            y         <= y_nx;
            vx        <= vx_nx;
            vy        <= vy_nx;
            hold_cnt  <= hold_cnt_nx;
            turn      <= turn_nx;
            owner     <= owner_nx;
            active    <= active_nx;
            cat_grant <= cat_grant_nx;
            dog_grant <= dog_grant_nx;
            landed    <= landed_nx;
        end
    end

    // y cannot go negative because of the ground clamp. The floor at 0 only
    // guards the unsigned output.
    assign x_pos = x;
    assign y_pos = y[12] ? 12'd0 : y[11:0];

endmodule

// File: tb/tb_projectile_ctl.sv
// -----------------------------------------------------------------------------
// tb_projectile_ctl
//
// Directed bench for projectile_ctl. The main instance uses the default
// parameters. With default gravity, a power-127 throw lands (x = 706) long
// before the far edge. The far-edge saturation is therefore exercised on a
// second, zero-gravity instance. On that instance, y rises by 35 per frame and
// x reaches 785 on frame 83.
// -----------------------------------------------------------------------------
module tb_projectile_ctl;

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        frame_tick, cat_req, dog_req;
    logic [6:0]  cat_power, dog_power;
    logic        cat_grant, dog_grant, active, owner, turn, landed;
    logic [11:0] x_pos, y_pos;

    // zero-gravity instance signals
    logic        xl_frame_tick, xl_cat_req, xl_dog_req;
    logic [6:0]  xl_cat_power, xl_dog_power;
    logic        xl_cat_grant, xl_dog_grant, xl_active, xl_owner, xl_turn, xl_landed;
    logic [11:0] xl_x_pos, xl_y_pos;

    projectile_ctl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .cat_req    (cat_req),
        .cat_power  (cat_power),
        .dog_req    (dog_req),
        .dog_power  (dog_power),
        .cat_grant  (cat_grant),
        .dog_grant  (dog_grant),
        .active     (active),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .owner      (owner),
        .turn       (turn),
        .landed     (landed)
    );

    projectile_ctl #(.GRAVITY(0)) dut_xl (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (xl_frame_tick),
        .cat_req    (xl_cat_req),
        .cat_power  (xl_cat_power),
        .dog_req    (xl_dog_req),
        .dog_power  (xl_dog_power),
        .cat_grant  (xl_cat_grant),
        .dog_grant  (xl_dog_grant),
        .active     (xl_active),
        .x_pos      (xl_x_pos),
        .y_pos      (xl_y_pos),
        .owner      (xl_owner),
        .turn       (xl_turn),
        .landed     (xl_landed)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick, followed by one idle cycle. l is landed as seen in the
    // cycle right after the tick, which is when the pulse is visible.
    task automatic do_tick(input bit xl, output logic l);
        if (xl) xl_frame_tick = 1'b1;
        else    frame_tick    = 1'b1;
        @(negedge clk);
        frame_tick    = 1'b0;
        xl_frame_tick = 1'b0;
        l = xl ? xl_landed : landed;
        @(negedge clk);
    endtask

    int ex_x [5] = '{42, 44, 46, 48, 50};
    int ex_y [5] = '{104, 107, 109, 110, 110};

    initial begin
        logic l;
        int   land_n;
        int   land_cnt;
        int   y18;
        int   x82;
        int   y82;

        rst_n         = 1'b0;
        frame_tick    = 1'b0;
        cat_req       = 1'b0;
        dog_req       = 1'b0;
        cat_power     = 7'd0;
        dog_power     = 7'd0;
        xl_frame_tick = 1'b0;
        xl_cat_req    = 1'b0;
        xl_dog_req    = 1'b0;
        xl_cat_power  = 7'd0;
        xl_dog_power  = 7'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_turn", turn, 0);
        chk("rst_owner", owner, 0);
        chk("rst_cat_grant", cat_grant, 0);
        chk("rst_dog_grant", dog_grant, 0);
        chk("rst_landed", landed, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests with a launch-cycle tick. The dog holds req
        // for the whole cat throw.
        cat_req    = 1'b1;
        dog_req    = 1'b1;
        frame_tick = 1'b1;
        cat_power  = 7'd0;
        dog_power  = 7'd20;   // vx = 3, vy = 9
        @(negedge clk);
        cat_req    = 1'b0;
        frame_tick = 1'b0;
        chk("launch_cat_grant", cat_grant, 1);
        chk("launch_dog_grant", dog_grant, 0);
        chk("launch_active", active, 1);
        chk("launch_owner", owner, 0);
        chk("launch_x", x_pos, 40);
        chk("launch_y", y_pos, 100);
        @(negedge clk);
        chk("grant_pulse_end", cat_grant, 0);
        chk("tick_in_launch_x", x_pos, 40);
        chk("tick_in_launch_y", y_pos, 100);

        // First five frames of the power-0 flight
        for (int n = 0; n < 5; n++) begin
            do_tick(1'b0, l);
            chk("frame_x", x_pos, ex_x[n]);
            chk("frame_y", y_pos, ex_y[n]);
            chk("frame_landed", l, 0);
            chk("frame_dog_grant", dog_grant, 0);
        end

        // Remaining frames up to the ground landing on frame 19
        land_n   = 0;
        land_cnt = 0;
        y18      = 0;
        for (int n = 6; n <= 19; n++) begin
            do_tick(1'b0, l);
            if (n == 18) y18 = int'(y_pos);
            if (l) begin
                land_n = n;
                land_cnt++;
            end
            chk("fly_dog_grant", dog_grant, 0);
        end
        chk("frame18_y", y18, 19);
        chk("ground_land_frame", land_n, 19);
        chk("ground_land_count", land_cnt, 1);
        chk("ground_x", x_pos, 78);
        chk("ground_y", y_pos, 15);
        chk("ground_active", active, 1);

        // Hold for 29 ticks: still visible, still the cat's turn
        land_cnt = 0;
        for (int h = 1; h < 30; h++) begin
            do_tick(1'b0, l);
            if (l) land_cnt++;
            chk("hold_dog_grant", dog_grant, 0);
        end
        chk("hold_landed_count", land_cnt, 0);
        chk("hold_active", active, 1);
        chk("hold_turn", turn, 0);
        chk("hold_y", y_pos, 15);

        // 30th hold tick releases the projectile and passes the turn
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("release_active", active, 0);
        chk("release_turn", turn, 1);
        chk("release_dog_grant", dog_grant, 0);
        @(negedge clk);
        dog_req = 1'b0;
        chk("dog_grant", dog_grant, 1);
        chk("dog_owner", owner, 1);
        chk("dog_active", active, 1);
        chk("dog_x", x_pos, 40);
        chk("dog_y", y_pos, 100);
        @(negedge clk);
        chk("dog_grant_once", dog_grant, 0);
        do_tick(1'b0, l);
        chk("dog_frame1_x", x_pos, 43);
        chk("dog_frame1_y", y_pos, 109);

        // Asynchronous reset mid-flight, between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_active", active, 0);
        chk("async_rst_x", x_pos, 0);
        chk("async_rst_y", y_pos, 0);
        chk("async_rst_turn", turn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_turn", turn, 0);
        chk("post_rst_active", active, 0);

        // A cat throw is accepted normally after reset
        cat_req   = 1'b1;
        cat_power = 7'd0;
        @(negedge clk);
        cat_req = 1'b0;
        chk("post_rst_cat_grant", cat_grant, 1);
        chk("post_rst_owner", owner, 0);
        chk("post_rst_x", x_pos, 40);
        chk("post_rst_y", y_pos, 100);

        // Far-edge saturation, power 127 (vx = 9, vy = 35), zero gravity
        xl_cat_req   = 1'b1;
        xl_cat_power = 7'd127;
        @(negedge clk);
        xl_cat_req = 1'b0;
        chk("xl_cat_grant", xl_cat_grant, 1);
        chk("xl_dog_grant", xl_dog_grant, 0);
        chk("xl_owner", xl_owner, 0);
        chk("xl_turn", xl_turn, 0);
        chk("xl_launch_x", xl_x_pos, 40);
        chk("xl_launch_y", xl_y_pos, 100);
        land_n   = 0;
        land_cnt = 0;
        x82      = 0;
        y82      = 0;
        for (int n = 1; n <= 83; n++) begin
            do_tick(1'b1, l);
            if (n == 82) begin
                x82 = int'(xl_x_pos);
                y82 = int'(xl_y_pos);
            end
            if (l) begin
                land_n = n;
                land_cnt++;
            end
        end
        chk("xl_frame82_x", x82, 778);
        chk("xl_frame82_y", y82, 2970);
        chk("xl_land_frame", land_n, 83);
        chk("xl_land_count", land_cnt, 1);
        chk("xl_x_sat", xl_x_pos, 785);
        chk("xl_y_free", xl_y_pos, 3005);
        chk("xl_active", xl_active, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
